// File: rtl/wavepool_fetch_arbiter_pkg.sv
// ============================================================================
// Module : wavepool_fetch_arbiter_pkg
// Brief  : Shared wavepool slot constants and types for the fetch arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wavepool_fetch_arbiter_pkg;

    localparam int WP_NUM_WF = 40;
    localparam int WP_WFID_W = 6;

    typedef logic [WP_WFID_W-1:0] wfid_t;
    typedef logic [WP_NUM_WF-1:0] slot_mask_t;

endpackage

`default_nettype wire

// File: rtl/wavepool_rr_pick.sv
// ============================================================================
// Module : wavepool_rr_pick
// Brief  : Combinational round-robin pick: first set bit strictly after start,
//          wrapping, with the start slot itself searched last.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wavepool_rr_pick
    import wavepool_fetch_arbiter_pkg::*;
#(
    parameter int N     = WP_NUM_WF,
    parameter int IDX_W = WP_WFID_W
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] winner,
    output logic             found
);

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        winner = '0;
        found  = |eligible;
        for (int k = N; k >= 1; k--) begin
            if (eligible[(int'(start) + k) % N]) begin
                winner = IDX_W'((int'(start) + k) % N);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wavepool_fetch_arbiter.sv
// ============================================================================
// Module : wavepool_fetch_arbiter
// Brief  : Round-robin fetch scheduler, one instruction in flight per slot.
//          Optional starvation override enabled by WAVEPOOL_FETCH_AGE_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wavepool_fetch_arbiter
    import wavepool_fetch_arbiter_pkg::*;
#(
    parameter int NUM_WF = WP_NUM_WF,
    parameter int WFID_W = WP_WFID_W,
    parameter int AGE_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_WF-1:0] valid_wf,
    input  logic [NUM_WF-1:0] q_nonempty,
    input  logic [NUM_WF-1:0] q_reset,
    input  logic              decode_ready,
    input  logic              done_en,
    input  logic [WFID_W-1:0] done_wfid,
    output logic              feed_valid,
    output logic [WFID_W-1:0] feed_wfid,
    output logic [NUM_WF-1:0] inflight_wf
);

    logic [NUM_WF-1:0] inflight_q, inflight_d;
    logic [WFID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [WFID_W-1:0] feed_wfid_q, feed_wfid_d;
    logic              feed_valid_q, feed_valid_d;

    logic [NUM_WF-1:0] eligible;
    logic [WFID_W-1:0] rr_winner;
    logic [WFID_W-1:0] winner;
    logic              rr_found;
    logic              grant;

    assign eligible = valid_wf & q_nonempty & ~inflight_q & ~q_reset;
    assign grant    = decode_ready & rr_found;

    wavepool_rr_pick #(
        .N     (NUM_WF),
        .IDX_W (WFID_W)
    ) u_rr_pick (
        .eligible (eligible),
        .start    (rr_ptr_q),
        .winner   (rr_winner),
        .found    (rr_found)
    );

`ifdef WAVEPOOL_FETCH_AGE_EN
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    logic [AGE_W-1:0]  age_q [NUM_WF];
    logic [AGE_W-1:0]  age_d [NUM_WF];
    logic [NUM_WF-1:0] starved;
    logic [WFID_W-1:0] starved_idx;

    // Lowest-index starved slot overrides the round-robin choice.
    always_comb begin
        starved_idx = '0;
        for (int i = NUM_WF - 1; i >= 0; i--) begin
            starved[i] = eligible[i] && (age_q[i] == AGE_MAX);
            if (starved[i]) begin
                starved_idx = WFID_W'(i);
            end
        end
    end

    assign winner = (|starved) ? starved_idx : rr_winner;

    always_comb begin
        for (int i = 0; i < NUM_WF; i++) begin
            if (!eligible[i] || (grant && (winner == WFID_W'(i)))) begin
                age_d[i] = '0;
            end else if (age_q[i] != AGE_MAX) begin
                age_d[i] = age_q[i] + AGE_W'(1);
            end else begin
                age_d[i] = age_q[i];
            end
        end
    end
`else
    logic [AGE_W-1:0] unused_age;
    assign unused_age = '0;
    assign winner     = rr_winner;
`endif

    // Releases land before the grant set; a granted slot is never a released one.
    always_comb begin
        inflight_d   = inflight_q & ~q_reset;
        rr_ptr_d     = rr_ptr_q;
        feed_wfid_d  = feed_wfid_q;
        feed_valid_d = grant;
        if (done_en && (32'(done_wfid) < NUM_WF)) begin
            inflight_d[done_wfid] = 1'b0;
        end
        if (grant) begin
            inflight_d[winner] = 1'b1;
            rr_ptr_d           = winner;
            feed_wfid_d        = winner;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight_q   <= '0;
            rr_ptr_q     <= WFID_W'(NUM_WF - 1);
            feed_wfid_q  <= '0;
            feed_valid_q <= 1'b0;
`ifdef WAVEPOOL_FETCH_AGE_EN
            for (int i = 0; i < NUM_WF; i++) begin
                age_q[i] <= '0;
            end
`endif
        end else begin
            inflight_q   <= inflight_d;
            rr_ptr_q     <= rr_ptr_d;
            feed_wfid_q  <= feed_wfid_d;
            feed_valid_q <= feed_valid_d;
`ifdef WAVEPOOL_FETCH_AGE_EN
            for (int i = 0; i < NUM_WF; i++) begin
                age_q[i] <= age_d[i];
            end
`endif
        end
    end

    assign feed_valid  = feed_valid_q;
    assign feed_wfid   = feed_wfid_q;
    assign inflight_wf = inflight_q;

endmodule

`default_nettype wire

// File: tb/tb_wavepool_fetch_arbiter.sv
// ============================================================================
// Module : tb_wavepool_fetch_arbiter
// Brief  : Scoreboard bench for wavepool_fetch_arbiter; expected grants are
//          queued by the stimulus and consumed by a negedge monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wavepool_fetch_arbiter;

    localparam int NUM_WF = 40;
    localparam int WFID_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_WF-1:0] valid_wf;
    logic [NUM_WF-1:0] q_nonempty;
    logic [NUM_WF-1:0] q_reset;
    logic              decode_ready;
    logic              done_en;
    logic [WFID_W-1:0] done_wfid;
    logic              feed_valid;
    logic [WFID_W-1:0] feed_wfid;
    logic [NUM_WF-1:0] inflight_wf;

    int total = 0;
    int bad   = 0;
    logic [WFID_W-1:0] exp_q[$];
    logic [WFID_W-1:0] mon_exp;

    wavepool_fetch_arbiter #(
        .NUM_WF (NUM_WF),
        .WFID_W (WFID_W),
        .AGE_W  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_wf     (valid_wf),
        .q_nonempty   (q_nonempty),
        .q_reset      (q_reset),
        .decode_ready (decode_ready),
        .done_en      (done_en),
        .done_wfid    (done_wfid),
        .feed_valid   (feed_valid),
        .feed_wfid    (feed_wfid),
        .inflight_wf  (inflight_wf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (feed_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL grant_unexpected: got wfid=%0d, expected no grant", feed_wfid);
            end else begin
                mon_exp = exp_q.pop_front();
                if (feed_wfid !== mon_exp) begin
                    bad++;
                    $display("FAIL grant_order: got wfid=%0d, expected wfid=%0d", feed_wfid, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [NUM_WF-1:0] mk(input int a, input int b = -1,
                                             input int c = -1, input int d = -1);
        logic [NUM_WF-1:0] m;
        m = '0;
        if (a >= 0) m[a] = 1'b1;
        if (b >= 0) m[b] = 1'b1;
        if (c >= 0) m[c] = 1'b1;
        if (d >= 0) m[d] = 1'b1;
        return m;
    endfunction

    initial begin
        rst = 1'b0; valid_wf = '0; q_nonempty = '0; q_reset = '0;
        decode_ready = 1'b0; done_en = 1'b0; done_wfid = '0;
        tick(); tick();
        chk("reset_feed_valid", 64'(feed_valid), 64'(0));
        chk("reset_feed_wfid", 64'(feed_wfid), 64'(0));
        chk("reset_inflight", 64'(inflight_wf), 64'(0));
        rst = 1'b1;

        // Three slots granted back to back in index order from reset.
        valid_wf = mk(0, 5, 39); q_nonempty = mk(0, 5, 39); decode_ready = 1'b1;
        exp_q.push_back(6'd0); exp_q.push_back(6'd5); exp_q.push_back(6'd39);
        tick(); tick(); tick(); tick();
        chk("rr_idle_after_three", 64'(feed_valid), 64'(0));
        chk("rr_inflight_three", 64'(inflight_wf), 64'(mk(0, 5, 39)));

        // Release slot 5; search after 39 wraps to 0 (busy) then finds 5.
        done_en = 1'b1; done_wfid = 6'd5;
        exp_q.push_back(6'd5);
        tick();
        done_en = 1'b0;
        tick(); tick();
        chk("regrant_inflight", 64'(inflight_wf), 64'(mk(0, 5, 39)));

        // Out-of-range and not-in-flight releases change nothing.
        done_en = 1'b1; done_wfid = 6'd45;
        tick();
        chk("done_out_of_range", 64'(inflight_wf), 64'(mk(0, 5, 39)));
        done_wfid = 6'd3;
        tick();
        done_en = 1'b0;
        chk("done_not_inflight", 64'(inflight_wf), 64'(mk(0, 5, 39)));

        valid_wf = '0; q_nonempty = '0; q_reset = '1;
        tick();
        q_reset = '0;
        chk("q_reset_all", 64'(inflight_wf), 64'(0));

        // decode_ready low holds the grant off.
        valid_wf = mk(7); q_nonempty = mk(7); decode_ready = 1'b0;
        tick(); tick(); tick();
        chk("stall_no_inflight", 64'(inflight_wf), 64'(0));
        decode_ready = 1'b1;
        exp_q.push_back(6'd7);
        tick(); tick();
        chk("stall_release_idle", 64'(feed_valid), 64'(0));

        // q_reset frees an in-flight slot for regrant.
        valid_wf = mk(7, 12); q_nonempty = mk(7, 12);
        exp_q.push_back(6'd12);
        tick(); tick();
        chk("slot12_inflight", 64'(inflight_wf), 64'(mk(7, 12)));
        q_reset = mk(12);
        tick();
        q_reset = '0;
        chk("slot12_flushed", 64'(inflight_wf), 64'(mk(7)));
        exp_q.push_back(6'd12);
        tick(); tick();
        chk("slot12_regranted", 64'(inflight_wf), 64'(mk(7, 12)));

        // Flushed slot loses the same-cycle grant to the next eligible slot.
        valid_wf = mk(7, 12, 20, 21); q_nonempty = mk(7, 12, 20, 21); q_reset = mk(20);
        exp_q.push_back(6'd21);
        tick();
        q_reset = '0;
        exp_q.push_back(6'd20);
        tick(); tick();
        chk("four_inflight", 64'(inflight_wf), 64'(mk(7, 12, 20, 21)));

        // Reset mid-operation, then a stale done_en is harmless.
        rst = 1'b0;
        tick();
        chk("midreset_inflight", 64'(inflight_wf), 64'(0));
        chk("midreset_feed_valid", 64'(feed_valid), 64'(0));
        rst = 1'b1; done_en = 1'b1; done_wfid = 6'd7;
        exp_q.push_back(6'd7);
        tick();
        done_en = 1'b0;
        exp_q.push_back(6'd12); exp_q.push_back(6'd20); exp_q.push_back(6'd21);
        tick(); tick(); tick(); tick();
        chk("post_reset_inflight", 64'(inflight_wf), 64'(mk(7, 12, 20, 21)));
        chk("post_reset_idle", 64'(feed_valid), 64'(0));

`ifdef WAVEPOOL_FETCH_AGE_EN
        rst = 1'b0; valid_wf = '0; q_nonempty = '0;
        tick();
        rst = 1'b1;
        valid_wf = mk(1); q_nonempty = mk(1);
        exp_q.push_back(6'd1);
        tick();
        // Slot 1 released while slot 2 waits; both age under a stall.
        valid_wf = mk(1, 2); q_nonempty = mk(1, 2); decode_ready = 1'b0;
        done_en = 1'b1; done_wfid = 6'd1;
        tick();
        done_en = 1'b0;
        tick(); tick(); tick();
        // Round-robin from pointer 1 would pick 2; starved slot 1 wins instead.
        decode_ready = 1'b1;
        exp_q.push_back(6'd1);
        tick();
        exp_q.push_back(6'd2);
        tick(); tick();
        chk("age_inflight", 64'(inflight_wf), 64'(mk(1, 2)));
`endif

        tick();
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wavepool_fetch_arbiter.md
Name: wavepool_fetch_arbiter

Overview:
- Round-robin scheduler that decides which wavefront slot the wavepool feeds to decode each cycle.
- Drives the pool's read-side feed_wfid/feed_valid pair.
- Keeps one instruction in flight per wavefront: a slot is not re-granted until decode/issue reports it done, or the slot is reset.
- Sits between the wavepool queue bank and the decode stage.

Parameters:
- NUM_WF, 40, number of wavefront slots.
- WFID_W, 6, wavefront id width; 2^WFID_W >= NUM_WF.
- AGE_W, 4, per-slot wait-counter width; used only with the optional feature.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-low (rst==0 resets on the clock edge).
- valid_wf  input  NUM_WF  per-slot "wavefront live" flags from the pool controller.
- q_nonempty  input  NUM_WF  per-slot "instruction queue holds at least one entry".
- q_reset  input  NUM_WF  per-slot flush (halt, branch taken, recover).
- decode_ready  input  1  decode can accept an instruction this cycle.
- done_en  input  1  issue reports completion of the in-flight instruction of done_wfid.
- done_wfid  input  WFID_W  slot being released.
- feed_valid  output  1  registered grant valid.
- feed_wfid  output  WFID_W  registered granted slot.
- inflight_wf  output  NUM_WF  per-slot in-flight flags; debug/observability.

Behaviour:
- Reset values: feed_valid=0, feed_wfid=0, inflight_wf=0. rr_ptr resets to NUM_WF-1, so the first grant searches from slot 0.
- Eligibility, per slot: eligible[i] = valid_wf[i] & q_nonempty[i] & ~inflight[i] & ~q_reset[i].
- Grant condition: decode_ready=1 and eligible nonzero. Select the first eligible index strictly after rr_ptr, searching upward and wrapping modulo NUM_WF. Slot rr_ptr itself is searched last.
- On a grant edge:
  - feed_valid<=1, feed_wfid<=winner.
  - inflight[winner]<=1, rr_ptr<=winner.
- With no grant: feed_valid<=0, and feed_wfid holds its previous value. Latency from eligibility to feed_valid is exactly 1 cycle.
- feed_valid is a one-cycle pulse per grant. Back-to-back grants to different slots occur on consecutive cycles.
- Release rules:
  - done_en=1 clears inflight[done_wfid] at the edge.
  - q_reset[i]=1 clears inflight[i] at the edge.
  - A release of a slot that is not in flight is a no-op.
  - done_wfid >= NUM_WF is ignored.
- Simultaneous events:
  - A grant cannot target a slot that is being released in the same cycle, because eligibility needs ~inflight. The released slot becomes eligible the next cycle.
  - q_reset on a slot in the same cycle that its grant would occur blocks the grant; search proceeds to the next eligible slot.
  - q_reset of the slot currently shown on feed_valid does not retract the pulse; the pool controller handles that flush.
- Wrap-around: with rr_ptr=NUM_WF-1, the search starts at slot 0.
- Reset mid-operation: every inflight bit and the pointer return to reset values. An outstanding done_en arriving after reset is a no-op.
- decode_ready=0 freezes rr_ptr and the inflight-set path. Releases are still processed.

Optional Feature:
- Macro: WAVEPOOL_FETCH_AGE_EN.
- When defined, each slot has an AGE_W-bit saturating wait counter:
  - Increments each cycle the slot is eligible but not granted.
  - Clears on grant, when the slot becomes ineligible, or on reset.
- Any slot whose counter equals 2^AGE_W-1 is "starved". If any starved slots exist, the lowest-index starved slot wins, overriding round-robin; rr_ptr still updates to the winner.
- When not defined: pure round-robin, and no counters are synthesized.

Decomposition:
- Shared package: NUM_WF and WFID_W constants, wfid typedef, and the NUM_WF-bit slot-mask typedef, shared with the pool controller.
- One natural sub-module: wavepool_rr_pick. It is combinational: it takes an eligible mask and a start pointer and returns winner index and found flag. It is reusable by other pool-side arbiters.

Test Plan:
- Release rr_ptr reset; valid_wf, q_nonempty = slots {0,5,39}; decode_ready=1; no done -> grants 0,5,39 on consecutive cycles, then feed_valid=0, inflight_wf = bits {0,5,39}.
- After the above, done_en with wfid 5 -> one cycle later slot 5 re-granted; rr_ptr wrap is confirmed because the search after 39 starts at 0, and 0 is not eligible.
- Slot 7 eligible, decode_ready=0 for 3 cycles -> no feed_valid. decode_ready=1 -> feed_wfid=7 the next cycle.
- Slot 12 in flight, q_reset[12]=1 -> inflight[12] clears. With valid_wf and q_nonempty still set, slot 12 is granted the following cycle.
- rst=0 asserted for one edge while 3 slots are in flight -> inflight_wf=0, feed_valid=0. The first grant after rst=1 is the lowest eligible slot.
- With WAVEPOOL_FETCH_AGE_EN and AGE_W=2: slots 1 and 2 eligible, slot 2 only ever granted by a forced pattern -> once slot 1's counter reaches 3, slot 1 wins the next grant.
